// File: rtl/st_disp_pkg.sv
// Shared display constants for st_indicator: mode codes, 7-seg glyphs {dp,g,f,e,d,c,b,a}
// and LED mapping helpers. Pure combinational helpers, no latency, no flow control.
package st_disp_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_SLEEP = 3'd1,
    ST_LIGHT = 3'd2,
    ST_DRAW  = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERASE = 3'd5,
    ST_COLOR = 3'd6,
    ST_STOP  = 3'd7
  } st_mode_e;

  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_R     = 8'h50;
  localparam logic [7:0] GLYPH_P     = 8'h73;
  localparam logic [7:0] GLYPH_S     = 8'h6D;
  localparam logic [7:0] GLYPH_T     = 8'h78;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = 8'h3F;
      4'd1:    g = 8'h06;
      4'd2:    g = 8'h5B;
      4'd3:    g = 8'h4F;
      4'd4:    g = 8'h66;
      4'd5:    g = 8'h6D;
      4'd6:    g = 8'h7D;
      4'd7:    g = 8'h07;
      4'd8:    g = 8'h7F;
      4'd9:    g = 8'h6F;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // One-hot LED position for the steady working modes.
  function automatic logic [2:0] led_idx(input st_mode_e m);
    logic [2:0] idx;
    case (m)
      ST_LIGHT: idx = 3'd1;
      ST_DRAW:  idx = 3'd2;
      ST_WRITE: idx = 3'd3;
      ST_ERASE: idx = 3'd4;
      ST_COLOR: idx = 3'd5;
      default:  idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [7:0] progress_bar(input logic [1:0] lvl);
    logic [7:0] bar;
    case (lvl)
      2'd0:    bar = 8'h03;
      2'd1:    bar = 8'h0F;
      2'd2:    bar = 8'h3F;
      default: bar = 8'hFF;
    endcase
    return bar;
  endfunction

endpackage

// File: rtl/seg_scan2.sv
// Two-digit multiplexed 7-seg scanner; dig_n and seg are registered together so a
// digit is never enabled with the other digit's pattern. One-cycle latency, no backpressure.
module seg_scan2
  import st_disp_pkg::*;
#(
  parameter int SCAN_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_sync,
  input  logic [7:0] i_left,
  input  logic [7:0] i_right,
  input  logic       i_blank,
  output logic [7:0] o_seg,
  output logic [1:0] o_dig_n
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  logic [SW-1:0] r_cnt;
  logic          r_sel;
  logic [SW-1:0] w_cnt_nxt;
  logic          w_sel_nxt;

  // r_sel = 0 drives the left digit; i_sync restarts the scan on the left.
  always_comb begin
    w_cnt_nxt = r_cnt + 1'b1;
    w_sel_nxt = r_sel;
    if (i_sync) begin
      w_cnt_nxt = '0;
      w_sel_nxt = 1'b0;
    end else if (r_cnt == SCAN_LAST) begin
      w_cnt_nxt = '0;
      w_sel_nxt = ~r_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      o_seg   <= GLYPH_BLANK;
      o_dig_n <= 2'b11;
    end else if (i_en) begin
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      o_dig_n <= w_sel_nxt ? 2'b10 : 2'b01;
      o_seg   <= i_blank ? GLYPH_BLANK : (w_sel_nxt ? i_right : i_left);
    end
  end

endmodule

// File: rtl/st_indicator.sv
// Turns st mode/sub-state codes into LEDs, a 2-digit display and a beep on mode change.
// Input to led/seg/beep latency is 2 edges; free-running sampler, no backpressure.
module st_indicator
  import st_disp_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SCAN_CYCLES = 50000,
  parameter int BEEP_CYCLES = CLK_FREQ / 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  logic [2:0] state_deep,
  output logic [7:0] led,
  output logic [7:0] seg,
  output logic [1:0] dig_n,
  output logic       beep
);

  localparam int BLINK_HALF = CLK_FREQ / 4;
  localparam int BLW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int BPW = $clog2(BEEP_CYCLES + 1);
  localparam logic [BLW-1:0] BLINK_LAST = BLW'(BLINK_HALF - 1);
  localparam logic [BPW-1:0] BEEP_LOAD  = BPW'(BEEP_CYCLES);

  logic [2:0]     r_state_q, r_deep_q, r_state_q1;
  logic           r_vld, r_primed;
  logic [BLW-1:0] r_blink_cnt;
  logic           r_blink_ph;
  logic [BPW-1:0] r_beep_cnt;
  logic [7:0]     r_led;

  st_mode_e       w_mode;
  logic [1:0]     w_level;
  logic           w_change;
  logic [BLW-1:0] w_blink_cnt_nxt;
  logic           w_blink_ph_nxt;
  logic [7:0]     w_led_nxt, w_left, w_right;
  logic           w_blank;
  logic           w_scan_sync;

  always_comb begin
    w_mode   = st_mode_e'(r_state_q);
    w_level  = (r_deep_q > 3'd3) ? 2'd3 : r_deep_q[1:0];
    w_change = r_primed && (r_state_q != r_state_q1);

    // Blink restarts lit on the first valid sample and on every mode change.
    w_blink_cnt_nxt = r_blink_cnt + 1'b1;
    w_blink_ph_nxt  = r_blink_ph;
    if (!r_primed || w_change) begin
      w_blink_cnt_nxt = '0;
      w_blink_ph_nxt  = 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      w_blink_cnt_nxt = '0;
      w_blink_ph_nxt  = ~r_blink_ph;
    end

    w_led_nxt = 8'h00;
    w_left    = GLYPH_BLANK;
    w_right   = GLYPH_BLANK;
    w_blank   = 1'b0;
    case (w_mode)
      ST_RST: begin
        w_led_nxt = progress_bar(w_level);
        w_left    = GLYPH_R;
        w_right   = digit_glyph({2'b00, w_level});
      end
      ST_SLEEP: begin
        w_led_nxt = {7'b0, w_blink_ph_nxt};
        w_left    = GLYPH_DASH;
        w_right   = GLYPH_DASH;
      end
      ST_STOP: begin
        w_led_nxt = {8{w_blink_ph_nxt}};
        w_left    = GLYPH_S;
        w_right   = GLYPH_T;
        w_blank   = ~w_blink_ph_nxt;
      end
      default: begin
        w_led_nxt = 8'h01 << led_idx(w_mode);
        w_left    = GLYPH_P;
        w_right   = digit_glyph({1'b0, r_state_q - 3'd1});
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q   <= 3'd0;
      r_deep_q    <= 3'd0;
      r_state_q1  <= 3'd0;
      r_vld       <= 1'b0;
      r_primed    <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_beep_cnt  <= '0;
      r_led       <= 8'h00;
    end else begin
      r_state_q   <= state;
      r_deep_q    <= state_deep;
      r_state_q1  <= r_state_q;
      r_vld       <= 1'b1;
      r_primed    <= r_vld;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_ph  <= w_blink_ph_nxt;
      if (w_change)
        r_beep_cnt <= BEEP_LOAD;
      else if (r_beep_cnt != '0)
        r_beep_cnt <= r_beep_cnt - 1'b1;
      if (r_vld)
        r_led <= w_led_nxt;
    end
  end

  assign w_scan_sync = ~r_primed;
  assign led         = r_led;
  assign beep        = (r_beep_cnt != '0);

  seg_scan2 #(
    .SCAN_CYCLES(SCAN_CYCLES)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (r_vld),
    .i_sync  (w_scan_sync),
    .i_left  (w_left),
    .i_right (w_right),
    .i_blank (w_blank),
    .o_seg   (seg),
    .o_dig_n (dig_n)
  );

endmodule
